// File: rtl/adv_pkg.sv
// Shared types and constants for the adventure-game command generator.
// Direction vectors are ordered {N,S,E,W}.
package adv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_FIRE,
    ST_RELEASE,
    ST_GAMEOVER
  } cmd_state_t;

  localparam int DIR_N = 3;
  localparam int DIR_S = 2;
  localparam int DIR_E = 1;
  localparam int DIR_W = 0;

  typedef logic [3:0] dir_vec_t;

  localparam logic [7:0] MOVE_CNT_MAX = 8'd255;

  function automatic logic is_onehot(dir_vec_t vec);
    return (vec != 4'd0) && ((vec & (vec - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/adv_cmd_gen_btn_sync.sv
// Multi-stage synchronizer for the four raw direction buttons.
// Pure flop chain with asynchronous active-low reset.
module btn_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] din,
  output logic [3:0] dout
);

  logic [3:0] q [SYNC_STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        q[i] <= 4'd0;
      end
    end else begin
      q[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        q[i] <= q[i-1];
      end
    end
  end

  assign dout = q[SYNC_STAGES-1];

endmodule

// File: rtl/adv_cmd_gen.sv
// Debounced single-press direction pulse generator with sword tracking
// and a win/death freeze for the adventure-game room state machine.
module adv_cmd_gen #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_n,
  input  logic       btn_s,
  input  logic       btn_e,
  input  logic       btn_w,
  input  logic       sw,
  input  logic       win,
  input  logic       d,
  output logic       n,
  output logic       s,
  output logic       e,
  output logic       w,
  output logic       v,
  output logic [7:0] move_cnt,
  output logic       game_over
);

  import adv_pkg::*;

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DEB = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] ONE = CW'(1);

  dir_vec_t   raw;
  dir_vec_t   bv;
  dir_vec_t   cand;
  dir_vec_t   cand_nx;
  cmd_state_t state;
  cmd_state_t state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic       fire;

  assign raw = {btn_n, btn_s, btn_e, btn_w};

  btn_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .din    (raw),
    .dout   (bv)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cand  <= 4'd0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cand  <= cand_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cand_nx  = cand;
    cnt_nx   = cnt;
    unique case (state)
      ST_IDLE: begin
        if (is_onehot(bv)) begin
          cand_nx  = bv;
          cnt_nx   = ONE;
          state_nx = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (bv == cand) begin
          if (cnt >= DEB) begin
            state_nx = ST_FIRE;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + ONE;
          end
        end else begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end
      end
      ST_FIRE: begin
        state_nx = ST_RELEASE;
        cnt_nx   = '0;
      end
      ST_RELEASE: begin
        if (bv != 4'd0) begin
          cnt_nx = '0;
        end else if (cnt == DEB - ONE) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + ONE;
        end
      end
      ST_GAMEOVER: begin
        state_nx = ST_GAMEOVER;
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase
    // win/death overrides every other transition
    if (win | d) begin
      state_nx = ST_GAMEOVER;
    end
  end

  assign fire = (state == ST_FIRE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      move_cnt <= 8'd0;
    end else if (fire && move_cnt != MOVE_CNT_MAX) begin
      move_cnt <= move_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v <= 1'b0;
    end else if (sw && state != ST_GAMEOVER) begin
      v <= 1'b1;
    end
  end

  assign n         = fire & cand[DIR_N];
  assign s         = fire & cand[DIR_S];
  assign e         = fire & cand[DIR_E];
  assign w         = fire & cand[DIR_W];
  assign game_over = (state == ST_GAMEOVER);

endmodule

// File: doc/adv_cmd_gen.md
# adv_cmd_gen

Player-command generator for the adventure-game datapath; it drives the room state machine's `n`/`s`/`e`/`w`/`v` inputs.
- Synchronizes and debounces four raw direction buttons, accepts only a single unambiguous press, and emits exactly one single-cycle direction pulse per press.
- Tracks sword possession from the room state machine's sword-room indication.
- Freezes on win or death until reset.
- Sits between the board push-buttons and the room state machine, on the same clock.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flop stages in the button synchronizer (≥2).
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized cycles required before a press is accepted (≥1, ≤255).

Ports:
- `clk`  in  1: system clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `btn_n`, `btn_s`, `btn_e`, `btn_w`  in  1 each: raw, asynchronous, active-high buttons.
- `sw`  in  1: room state machine is in the sword room.
- `win`  in  1: room state machine reached the win state.
- `d`  in  1: room state machine reached the death state.
- `n`, `s`, `e`, `w`  out  1 each: one-cycle move pulses, mutually exclusive.
- `v`  out  1: player holds the vorpal sword (level).
- `move_cnt`  out  8: accepted moves, saturating.
- `game_over`  out  1: block frozen.

## Operation
- Buttons pass through the `SYNC_STAGES` synchronizer, giving the 4-bit vector `bv` in order {N,S,E,W}.
- FSM states: IDLE, ARMED, FIRE, RELEASE, GAMEOVER.
- IDLE:
  - `bv` one-hot: capture it as `cand`, load stable counter = 1, go to ARMED.
  - `bv` zero or multi-hot: stay.
- ARMED:
  - `bv == cand`: counter increments; when counter reaches `DEBOUNCE_CYCLES`, go to FIRE.
  - `bv != cand` (release, bounce, or a second button): go to IDLE and clear the counter.
- FIRE: lasts exactly one cycle.
  - The direction output selected by `cand` is high.
  - `move_cnt` increments, saturating at 255.
  - Go to RELEASE.
- RELEASE:
  - Wait until `bv == 0` for `DEBOUNCE_CYCLES` consecutive cycles, then go to IDLE.
  - Any nonzero `bv` restarts the count.
  - Holding a button never produces a second pulse.
- GAMEOVER:
  - Entered from any state on the edge after `win | d` is sampled high. This has priority over every other transition.
  - Left only by reset. No pulses; `v` and `move_cnt` are held.
- Sword: `v` is set on the edge after `sw` is sampled high and is cleared only by reset. `sw` is ignored in GAMEOVER.
- Direction outputs decode from the registered state and `cand` only, so they are glitch-free and at most one is high at a time.
- Reset values: state IDLE, `cand` 0, counters 0, `n`/`s`/`e`/`w` 0, `v` 0, `move_cnt` 0, `game_over` 0, synchronizer flops 0.

## Timing
- Latency: raw press first sampled at edge 0 and held clean → direction pulse high in the cycle after edge `SYNC_STAGES + DEBOUNCE_CYCLES`. With defaults, that is the cycle after edge 6. Pulse width is exactly 1 cycle.
- Minimum spacing between two accepted moves: FIRE, plus `DEBOUNCE_CYCLES` release cycles, plus a full new debounce.
- `win`/`d` high during a FIRE cycle: that pulse is still emitted; GAMEOVER follows on the next edge.
- `win`/`d` high during ARMED: no pulse is ever emitted for that press.
- `game_over` asserts one cycle after `win | d` is sampled high.
- `reset_n` low mid-operation (any state, including mid-debounce or FIRE): outputs are forced to reset values immediately, asynchronously. Deassertion takes effect on the next `clk` edge.
- `move_cnt` at 255 plus a FIRE: the pulse is still emitted and the count stays 255.

## Structure
- Package `adv_pkg`:
  - state enum `cmd_state_t`
  - direction index constants `DIR_N=3`, `DIR_S=2`, `DIR_E=1`, `DIR_W=0`
  - 4-bit one-hot type `dir_vec_t`
  - `MOVE_CNT_MAX = 8'd255`
- Sub-module `btn_sync`: parameterized `SYNC_STAGES`-deep flop chain on the 4-bit button vector. It has the same async active-low reset and no other logic.
- Top level holds the FSM, the debounce counter (width sized by `$clog2(DEBOUNCE_CYCLES+1)`), `cand`, the sword flag and `move_cnt`.

## Test plan
- Clean `btn_e` press held 20 cycles (defaults) → `e` high for exactly 1 cycle, 6 cycles after the first sampling edge; `move_cnt` = 1; no further pulse until release.
- `btn_n` bouncing 1-0-1-0 at 1-cycle intervals, then stable 10 cycles → exactly one `n` pulse, timed from the last rising edge.
- `btn_s` and `btn_w` pressed together for 20 cycles → no pulse. Release `btn_w` while `btn_s` stays held → one `s` pulse after the debounce.
- `sw` high 1 cycle → `v` = 1 next cycle and stays 1 through 10 later moves. `reset_n` low → `v` = 0 immediately.
- `d` high while ARMED on `btn_w` → no `w` pulse; `game_over` = 1 next cycle; later presses produce nothing; `move_cnt` held.
- 260 press/release cycles → `move_cnt` saturates at 255 and pulses continue. `reset_n` pulsed mid-debounce → all outputs 0 and state IDLE.
